rr_mux_arbiter: RTL and testbench

- Shares one NB_DATA-wide datapath between 4 requesters using round-robin arbitration with bounded bursts.
- Drives the select of the team's 4:1 data mux (Mux4_1).
- Registers the winning word into an output stage that uses a valid/ready handshake toward the consumer, e.g. the shared memory/debug write port of the MIPS pipeline.
- Sustains one transfer per clock when the consumer is ready.

---
 rtl/rr_arb_pkg.sv | 20 ++
 rtl/mux4_1.sv | 12 +
 rtl/rr_pick4.sv | 29 ++
 rtl/rr_mux_arbiter.sv | 75 +++++++
 tb/tb_rr_mux_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arb_pkg.sv
// Shared constants and helpers for the round-robin mux arbiter.
// Holds the state encoding, the requester count and a ceil-log2 helper.
package rr_arb_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    localparam int N_REQ = 4;

    // Ceil-log2, usable in constant expressions; returns 0 for 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mux4_1.sv
// Plain 4:1 word multiplexer over a flattened input bus.
module Mux4_1 #(
    parameter int NB_DATA = 32
) (
    input  logic [4*NB_DATA-1:0] words,
    input  logic [1:0]           sel,
    output logic [NB_DATA-1:0]   word
);

    assign word = words[sel*NB_DATA +: NB_DATA];

endmodule

// File: rtl/rr_pick4.sv
// Round-robin pick for four requesters: first set request after ptr, wrapping.
// The last-granted requester is scanned last, so it only wins when alone.
module rr_pick4 #(
    parameter int NB_SEL = 2
) (
    input  logic [3:0]        req,
    input  logic [NB_SEL-1:0] ptr,
    output logic [NB_SEL-1:0] idx,
    output logic              any
);

    logic [NB_SEL-1:0] cand;
    logic              found;

    always_comb begin
        idx   = ptr;
        found = 1'b0;
        cand  = ptr;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr + NB_SEL'(i);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one datapath among four
// requesters; the winning word is registered behind a valid/ready output stage.
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NB_DATA   = 32,
    parameter int NB_SEL    = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*NB_DATA-1:0] data_i,
    output logic [N_REQ-1:0]         ack_o,
    output logic [NB_DATA-1:0]       data_o,
    output logic                     valid_o,
    output logic [NB_SEL-1:0]        sel_o,
    input  logic                     ready_i
);

    localparam int                BEAT_W   = clog2(MAX_BURST + 1);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST);

    logic               state;
    logic [NB_SEL-1:0]  ptr;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [NB_SEL-1:0]  pick_idx;
    logic               pick_any;
    logic [NB_SEL-1:0]  mux_sel;
    logic [NB_DATA-1:0] mux_word;
    logic               xfer;
    logic               cont;
    logic               load;

    rr_pick4 #(.NB_SEL(NB_SEL)) u_pick (
        .req (req_i),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    Mux4_1 #(.NB_DATA(NB_DATA)) u_mux (
        .words (data_i),
        .sel   (mux_sel),
        .word  (mux_word)
    );

    assign valid_o = (state == ST_BUSY);
    assign xfer    = valid_o & ready_i;

    // Burst continuation takes precedence over re-arbitration on a transfer.
    assign cont    = (state == ST_BUSY) && req_i[sel_o] && (beat_cnt < BEAT_MAX);
    assign load    = (state == ST_IDLE) ? pick_any : (xfer && (cont || pick_any));
    assign mux_sel = cont ? sel_o : pick_idx;
    assign ack_o   = load ? (N_REQ'(1) << mux_sel) : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state    <= ST_IDLE;
            data_o   <= '0;
            sel_o    <= '0;
            ptr      <= NB_SEL'(N_REQ - 1);
            beat_cnt <= '0;
        end else if (load) begin
            state    <= ST_BUSY;
            data_o   <= mux_word;
            sel_o    <= mux_sel;
            ptr      <= mux_sel;
            beat_cnt <= cont ? beat_cnt + BEAT_W'(1) : BEAT_W'(1);
        end else if (xfer) begin
            state    <= ST_IDLE;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: one instance with bursts of 4, one with
// bursts of 1, sharing the same stimulus.
module tb_rr_mux_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] data;
    logic         ready;

    logic [3:0]   ack4, ack1;
    logic [31:0]  dout4, dout1;
    logic         valid4, valid1;
    logic [1:0]   sel4, sel1;

    int checks;
    int failures;

    rr_mux_arbiter #(.NB_DATA(32), .NB_SEL(2), .MAX_BURST(4)) dut4 (
        .clk_i(clk), .reset_i(reset), .req_i(req), .data_i(data),
        .ack_o(ack4), .data_o(dout4), .valid_o(valid4), .sel_o(sel4),
        .ready_i(ready)
    );

    rr_mux_arbiter #(.NB_DATA(32), .NB_SEL(2), .MAX_BURST(1)) dut1 (
        .clk_i(clk), .reset_i(reset), .req_i(req), .data_i(data),
        .ack_o(ack1), .data_o(dout1), .valid_o(valid1), .sel_o(sel1),
        .ready_i(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int k, input logic [31:0] w);
        data[k*32 +: 32] = w;
    endtask

    task automatic do_reset();
        req   = 4'b0000;
        ready = 1'b0;
        data  = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (valid4 !== 1'b0 || dout4 !== 32'h0 || sel4 !== 2'd0 || ack4 !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state: valid=%b data=%h sel=%0d ack=%b, want 0/0/0/0000",
                     valid4, dout4, sel4, ack4);
        end
        req = 4'b0100;
        set_word(2, 32'h0000_00C2);
        tick();
        checks++;
        if (valid4 !== 1'b1 || sel4 !== 2'd2 || dout4 !== 32'h0000_00C2) begin
            failures++;
            $display("FAIL reset_setup_busy: valid=%b sel=%0d data=%h, want 1/2/000000c2",
                     valid4, sel4, dout4);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (valid4 !== 1'b0 || dout4 !== 32'h0 || sel4 !== 2'd0) begin
            failures++;
            $display("FAIL reset_async_midbusy: valid=%b data=%h sel=%0d, want 0/0/0",
                     valid4, dout4, sel4);
        end
        reset = 1'b0;
        req   = 4'b1111;
        ready = 1'b1;
        #1;
        checks++;
        if (ack4 !== 4'b0001) begin
            failures++;
            $display("FAIL reset_first_ack: ack=%b, want 0001", ack4);
        end
        tick();
        checks++;
        if (sel4 !== 2'd0 || valid4 !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_pick: sel=%0d valid=%b, want 0/1", sel4, valid4);
        end
    endtask

    task automatic test_single();
        logic [31:0] exp_word;
        do_reset();
        ready = 1'b1;
        req   = 4'b0100;
        set_word(2, 32'hA0);
        #1;
        checks++;
        if (valid4 !== 1'b0) begin
            failures++;
            $display("FAIL single_latency: valid=%b before edge, want 0", valid4);
        end
        for (int i = 0; i < 5; i++) begin
            exp_word = 32'hA0 + 32'(i);
            checks++;
            if (ack4 !== 4'b0100) begin
                failures++;
                $display("FAIL single_ack[%0d]: ack=%b, want 0100", i, ack4);
            end
            tick();
            checks++;
            if (valid4 !== 1'b1 || sel4 !== 2'd2 || dout4 !== exp_word) begin
                failures++;
                $display("FAIL single_beat[%0d]: valid=%b sel=%0d data=%h, want 1/2/%h",
                         i, valid4, sel4, dout4, exp_word);
            end
            set_word(2, exp_word + 32'h1);
            #1;
        end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_sel;
        do_reset();
        ready = 1'b1;
        req   = 4'b1111;
        #1;
        for (int i = 0; i < 8; i++) begin
            exp_sel = 2'(i % 4);
            checks++;
            if (ack1 !== (4'b0001 << exp_sel)) begin
                failures++;
                $display("FAIL fair_ack[%0d]: ack=%b, want %b", i, ack1, 4'b0001 << exp_sel);
            end
            tick();
            checks++;
            if (sel1 !== exp_sel) begin
                failures++;
                $display("FAIL fair_sel[%0d]: sel=%0d, want %0d", i, sel1, exp_sel);
            end
        end
    endtask

    task automatic test_burst_limit();
        logic [1:0] exp_seq [9];
        exp_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
        do_reset();
        ready = 1'b1;
        req   = 4'b0011;
        #1;
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++;
            if (sel4 !== exp_seq[i] || valid4 !== 1'b1) begin
                failures++;
                $display("FAIL burst_sel[%0d]: sel=%0d valid=%b, want %0d/1",
                         i, sel4, valid4, exp_seq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] toggles [3];
        toggles = '{4'b1111, 4'b0000, 4'b0110};
        do_reset();
        req = 4'b0001;
        set_word(0, 32'h1234_5678);
        set_word(1, 32'h0000_BEEF);
        set_word(2, 32'h0000_CAFE);
        tick();
        checks++;
        if (valid4 !== 1'b1 || dout4 !== 32'h1234_5678 || sel4 !== 2'd0) begin
            failures++;
            $display("FAIL bp_load: valid=%b data=%h sel=%0d, want 1/12345678/0",
                     valid4, dout4, sel4);
        end
        for (int i = 0; i < 3; i++) begin
            req = toggles[i];
            #1;
            checks++;
            if (ack4 !== 4'b0000) begin
                failures++;
                $display("FAIL bp_ack[%0d]: ack=%b, want 0000", i, ack4);
            end
            tick();
            checks++;
            if (valid4 !== 1'b1 || dout4 !== 32'h1234_5678 || sel4 !== 2'd0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h sel=%0d, want 1/12345678/0",
                         i, valid4, dout4, sel4);
            end
        end
        ready = 1'b1;
        req   = 4'b0010;
        #1;
        checks++;
        if (ack4 !== 4'b0010) begin
            failures++;
            $display("FAIL bp_release_ack: ack=%b, want 0010", ack4);
        end
        tick();
        checks++;
        if (valid4 !== 1'b1 || dout4 !== 32'h0000_BEEF || sel4 !== 2'd1) begin
            failures++;
            $display("FAIL bp_release_load: valid=%b data=%h sel=%0d, want 1/0000beef/1",
                     valid4, dout4, sel4);
        end
    endtask

    task automatic test_drain();
        req = 4'b0000;
        #1;
        checks++;
        if (ack4 !== 4'b0000 || valid4 !== 1'b1) begin
            failures++;
            $display("FAIL drain_pre: ack=%b valid=%b, want 0000/1", ack4, valid4);
        end
        tick();
        checks++;
        if (valid4 !== 1'b0 || ack4 !== 4'b0000) begin
            failures++;
            $display("FAIL drain_fall: valid=%b ack=%b, want 0/0000", valid4, ack4);
        end
        tick();
        checks++;
        if (valid4 !== 1'b0 || ack4 !== 4'b0000 || dout4 !== 32'h0000_BEEF) begin
            failures++;
            $display("FAIL drain_idle: valid=%b ack=%b data=%h, want 0/0000/0000beef",
                     valid4, ack4, dout4);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        req      = 4'b0000;
        ready    = 1'b0;
        data     = '0;
        test_reset();
        test_single();
        test_fairness();
        test_burst_limit();
        test_backpressure();
        test_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
